// File: rtl/opcode_issue_queue_pkg.sv
// Shared widths, opcode field layout and FSM encoding for the opcode issue queue.
package opcode_issue_queue_pkg;
    localparam int OPC_W   = 21;
    localparam int OP_LSB  = 0;
    localparam int OP_W    = 4;
    localparam int A_LSB   = 4;
    localparam int A_W     = 8;
    localparam int B_LSB   = 12;
    localparam int B_W     = 8;
    localparam int ACC_BIT = 20;
    localparam int ANS_W   = 8;
    localparam int CNT_W   = 5;
    localparam int LAT_W   = 3;

    typedef logic [OPC_W-1:0] opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_e;

    function automatic opcode_t mk_opcode(input logic acc, input logic [B_W-1:0] b,
                                          input logic [A_W-1:0] a, input logic [OP_W-1:0] op);
        opcode_t o;
        o                 = '0;
        o[ACC_BIT]        = acc;
        o[B_LSB +: B_W]   = b;
        o[A_LSB +: A_W]   = a;
        o[OP_LSB +: OP_W] = op;
        return o;
    endfunction
endpackage

// File: rtl/opcode_issue_queue_if.sv
// Host / control-stage signal bundle for the opcode issue queue.
interface opcode_issue_queue_if;
    import opcode_issue_queue_pkg::*;

    logic              push_in;
    opcode_t           opcode_in;
    logic              run_in;
    logic [ANS_W-1:0]  ans_in;
    opcode_t           op_out;
    logic              en_out;
    logic [ANS_W-1:0]  ans_out;
    logic              ans_valid_out;
    logic              full_out;
    logic              empty_out;
    logic [CNT_W-1:0]  count_out;
    logic              busy_out;
    logic              overflow_out;

    modport master (
        output push_in, opcode_in, run_in, ans_in,
        input  op_out, en_out, ans_out, ans_valid_out, full_out, empty_out,
               count_out, busy_out, overflow_out
    );

    modport slave (
        input  push_in, opcode_in, run_in, ans_in,
        output op_out, en_out, ans_out, ans_valid_out, full_out, empty_out,
               count_out, busy_out, overflow_out
    );
endinterface

// File: rtl/opcode_issue_queue_fifo.sv
// Opcode FIFO: storage, wrapping pointers, occupancy and sticky overflow flag.
module opcode_fifo
    import opcode_issue_queue_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  opcode_t          din,
    input  logic             pop,
    output opcode_t          head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             overflow
);
    localparam int PTR_W = $clog2(DEPTH);

    opcode_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] cnt;
    logic             accept, do_pop;

    assign full   = (cnt == CNT_W'(DEPTH));
    assign empty  = (cnt == '0);
    assign count  = cnt;
    assign head   = mem[rd_ptr];
    assign accept = push && !full;
    assign do_pop = pop && !empty;

    // Storage is left unreset; contents are meaningless after reset anyway.
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({accept, do_pop})
                2'b10:   cnt <= cnt + CNT_W'(1);
                2'b01:   cnt <= cnt - CNT_W'(1);
                default: cnt <= cnt;
            endcase
            if (push && full) overflow <= 1'b1;
        end
    end
endmodule

// File: rtl/opcode_issue_queue.sv
// Issues queued opcodes one at a time to the ALU control stage and captures
// each result LATENCY cycles after the issue strobe.
module opcode_issue_queue
    import opcode_issue_queue_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int LATENCY = 1
) (
    input  logic          clk_in,
    input  logic          rst_in,
    opcode_issue_queue_if.slave bus
);
    localparam logic [LAT_W-1:0] WAIT_LOAD = LAT_W'(LATENCY - 1);

    state_e           state_q, state_d;
    logic [LAT_W-1:0] wcnt_q, wcnt_d;
    opcode_t          head, last_op;
    logic [ANS_W-1:0] ans_q;
    logic             ans_vld_q;
    logic             pop, cap, empty;

    opcode_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk      (clk_in),
        .rst      (rst_in),
        .push     (bus.push_in),
        .din      (bus.opcode_in),
        .pop      (pop),
        .head     (head),
        .count    (bus.count_out),
        .full     (bus.full_out),
        .empty    (empty),
        .overflow (bus.overflow_out)
    );

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        pop     = 1'b0;
        cap     = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.run_in && !empty) state_d = ST_ISSUE;
            ST_ISSUE: begin
                pop     = 1'b1;
                state_d = ST_WAIT;
                wcnt_d  = WAIT_LOAD;
            end
            ST_WAIT: begin
                // Result window closes here regardless of run_in.
                if (wcnt_q == '0) begin
                    cap     = 1'b1;
                    state_d = (bus.run_in && !empty) ? ST_ISSUE : ST_IDLE;
                end else begin
                    wcnt_d = wcnt_q - LAT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q   <= ST_IDLE;
            wcnt_q    <= '0;
            last_op   <= '0;
            ans_q     <= '0;
            ans_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wcnt_q    <= wcnt_d;
            if (state_q == ST_ISSUE) last_op <= head;
            if (cap) ans_q <= bus.ans_in;
            ans_vld_q <= cap;
        end
    end

    assign bus.op_out        = (state_q == ST_ISSUE) ? head : last_op;
    assign bus.en_out        = (state_q == ST_ISSUE);
    assign bus.busy_out      = (state_q != ST_IDLE);
    assign bus.empty_out     = empty;
    assign bus.ans_out       = ans_q;
    assign bus.ans_valid_out = ans_vld_q;
endmodule
